// File: rtl/fpga_bram_ctrl.sv
// rtl/fpga_bram_ctrl.sv - CPU request FSM with TX word FIFO and response capture over a shared word bus
module fpga_bram_ctrl #(
  parameter int ADDRESS_DATA_WIDTH = 33,
  parameter int TX_DEPTH           = 4
) (
  input  logic                          fpga_clk,
  input  logic                          rst,
  input  logic [31:0]                   cpu_addr,
  input  logic                          cpu_read,
  input  logic                          cpu_write,
  input  logic [63:0]                   cpu_wdata,
  output logic                          cpu_ready,
  output logic                          cpu_resp,
  output logic [63:0]                   cpu_rdata,
  input  logic                          r_en_CPU_to_FPGA_FIFO,
  input  logic                          w_en_FPGA_to_CPU_FIFO,
  output logic                          empty_CPU_to_FPGA_FIFO,
  output logic                          full_FPGA_to_CPU_FIFO,
  inout  wire  [ADDRESS_DATA_WIDTH-1:0] address_data_bus,
  output logic                          bus_error
);

  localparam int W  = ADDRESS_DATA_WIDTH;
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, RESP} state_t;

  state_t        state;
  logic          op_read;
  logic [31:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [1:0]    send_idx;
  logic [1:0]    resp_left;
  logic [31:0]   rdata_lo;

  logic [W-1:0]  tx_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   tx_count;

  logic [W-1:0]  push_word;
  logic          push;
  logic          pop;
  logic          capture;
  logic          last_send;
  logic          tag_bad;
  logic          violation;

  assign empty_CPU_to_FPGA_FIFO = (tx_count == '0);
  assign full_FPGA_to_CPU_FIFO  = !((state == WAIT_RESP) && (resp_left != 2'd0));
  assign cpu_ready              = (state == IDLE) && !rst;

  // A pop is only honoured when the memory is not also writing, so the bus never has two drivers
  assign pop     = r_en_CPU_to_FPGA_FIFO && !w_en_FPGA_to_CPU_FIFO && !empty_CPU_to_FPGA_FIFO && !rst;
  assign capture = w_en_FPGA_to_CPU_FIFO && !r_en_CPU_to_FPGA_FIFO && !full_FPGA_to_CPU_FIFO;
  assign push    = (state == SEND) && (tx_count != DEPTH_L);

  assign address_data_bus = pop ? tx_mem[rd_ptr] : {W{1'bz}};

  assign last_send = op_read ? (send_idx == 2'd0) : (send_idx == 2'd2);
  assign tag_bad   = op_read ? address_data_bus[W-1] : !address_data_bus[W-1];
  assign violation = (r_en_CPU_to_FPGA_FIFO && w_en_FPGA_to_CPU_FIFO)
                   || (r_en_CPU_to_FPGA_FIFO && empty_CPU_to_FPGA_FIFO)
                   || (w_en_FPGA_to_CPU_FIFO && full_FPGA_to_CPU_FIFO)
                   || (capture && tag_bad);

  // Select the request word for the current SEND step: address, then low and high write data
  always_comb begin
    push_word = '0;
    case (send_idx)
      2'd0:    push_word = {1'b1, addr_q};
      2'd1:    push_word = {1'b0, wdata_q[31:0]};
      2'd2:    push_word = {1'b0, wdata_q[63:32]};
      default: push_word = '0;
    endcase
  end

  // Request sequencing, response collection and CPU-side completion
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state     <= IDLE;
      op_read   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      send_idx  <= '0;
      resp_left <= '0;
      rdata_lo  <= '0;
      cpu_resp  <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_read || cpu_write) begin
            op_read  <= cpu_read;
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            send_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (push) begin
            if (last_send) begin
              state     <= WAIT_RESP;
              resp_left <= op_read ? 2'd2 : 2'd1;
            end else begin
              send_idx <= send_idx + 2'd1;
            end
          end
        end
        WAIT_RESP: begin
          if (capture) begin
            resp_left <= resp_left - 2'd1;
            if (op_read && (resp_left == 2'd2)) begin
              rdata_lo <= address_data_bus[31:0];
            end
            if (resp_left == 2'd1) begin
              state    <= RESP;
              cpu_resp <= 1'b1;
              if (op_read) begin
                cpu_rdata <= {address_data_bus[31:0], rdata_lo};
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // TX FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge fpga_clk) begin
    if (push) begin
      tx_mem[wr_ptr] <= push_word;
    end
  end

  // TX FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      bus_error <= 1'b0;
    end else if (violation) begin
      bus_error <= 1'b1;
    end
  end

endmodule

// File: doc/fpga_bram_ctrl.md
FPGA_BRAM_CTRL -- requirements
Module: fpga_bram_ctrl

Interface
REQ-001 Parameter: ADDRESS_DATA_WIDTH, 33, bus word width; bit 32 is the tag, bits 31:0 are the payload; only 33 is supported.
REQ-002 Parameter: TX_DEPTH, 4, CPU->FPGA word FIFO depth; power of two, at least 4.
REQ-003 fpga_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cpu_addr  in  32  request address.
REQ-006 cpu_read  in  1  read request.
REQ-007 cpu_write  in  1  write request.
REQ-008 cpu_wdata  in  64  write data.
REQ-009 cpu_ready  out  1  request accepted at this edge (high only in IDLE).
REQ-010 cpu_resp  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata  out  64  read data; valid while cpu_resp=1.
REQ-012 r_en_CPU_to_FPGA_FIFO  in  1  memory pops the head word.
REQ-013 w_en_FPGA_to_CPU_FIFO  in  1  memory pushes a response word.
REQ-014 empty_CPU_to_FPGA_FIFO  out  1  TX FIFO empty.
REQ-015 full_FPGA_to_CPU_FIFO  out  1  controller cannot accept a response word.
REQ-016 address_data_bus  inout  33  shared bidirectional word bus.
REQ-017 bus_error  out  1  sticky protocol-violation flag.

Function
REQ-018 The FSM SHALL have four states: IDLE, SEND, WAIT_RESP, RESP.
REQ-019 Request encoding: a read is one word, {1, addr}; a write is three words, {1, addr}, {0, wdata[31:0]}, {0, wdata[63:32]}.
REQ-020 Response encoding: a read returns two words, {0, rdata[31:0]} then {0, rdata[63:32]}; a write returns one ack word, {1, 32'h0}.
REQ-021 IDLE: cpu_ready=1. cpu_read or cpu_write at an edge latches addr, wdata and the op, then goes to SEND. If both are high, the read wins.
REQ-022 SEND: one word is pushed into the TX FIFO per edge, in encoding order. After the last push the FSM goes to WAIT_RESP. Read: 1 edge. Write: 3 edges.
REQ-023 empty_CPU_to_FPGA_FIFO SHALL equal (TX count == 0), from registered pointers.
REQ-024 When r_en_CPU_to_FPGA_FIFO=1 and empty=0: the bus is driven combinationally with the head word that cycle, and the word is popped at the edge. Otherwise the controller drives 'z.
REQ-025 full_FPGA_to_CPU_FIFO SHALL be 0 only in WAIT_RESP while expected response words remain; otherwise it is 1.
REQ-026 When w_en_FPGA_to_CPU_FIFO=1 and full=0: the bus word is captured at the edge and the remaining-word counter decrements. The memory side drives the bus in this case.
REQ-027 When the last expected word is captured, the FSM goes to RESP.
REQ-028 RESP: cpu_resp=1 for exactly one cycle, cpu_rdata = {high word, low word}, then IDLE. For a write, cpu_rdata holds its previous value.
REQ-029 A push and a pop in the same edge SHALL both take effect. TX pointers wrap modulo TX_DEPTH.
REQ-030 bus_error SHALL be set at the edge after any of the following:
- r_en and w_en both high;
- r_en while empty;
- w_en while full;
- a read-response word with tag=1, or a write ack with tag=0.
REQ-031 Offending words are ignored, with two exceptions: a bad-tag word is still captured, and a pop on a simultaneous r_en/w_en is suppressed. bus_error is cleared only by rst.
REQ-032 Only one request is outstanding at a time. cpu_read and cpu_write are ignored outside IDLE.

Reset
REQ-033 Values while rst is high:
- FSM = IDLE; TX FIFO flushed, so empty=1;
- full=1, cpu_ready=0, cpu_resp=0, cpu_rdata=0, bus_error=0;
- bus released ('z).
REQ-034 Reset mid-transaction SHALL discard the pending request and any partial response, with no cpu_resp.
REQ-035 cpu_ready SHALL become 1 in the first cycle after rst deasserts.

Verification
REQ-036 Read at addr 0x0000_1000:
- TX pops yield {1,0x00001000};
- response words {0,0xDEADBEEF} then {0,0x01234567} give cpu_rdata=0x01234567_DEADBEEF and a single cpu_resp pulse;
- cpu_resp occurs 1 cycle after the second capture.
REQ-037 Write at addr 0x20, wdata 0xAAAA_BBBB_CCCC_DDDD:
- TX pops yield {1,0x20}, {0,0xCCCCDDDD}, {0,0xAAAABBBB};
- ack {1,0} gives cpu_resp with no rdata change.
REQ-038 The memory holds r_en low until the FSM reaches WAIT_RESP, then pops all 3 write words back-to-back. Required: empty 0->1 exactly after the third pop, and no word is lost or reordered.
REQ-039 Protocol violations, each in a separate run:
- r_en with empty=1;
- r_en and w_en together;
- w_en during SEND.
Required for each: bus_error=1 the next cycle and staying set; FIFO contents and response counter unchanged.
REQ-040 Assert rst while a read is in WAIT_RESP with one of two words received. Required: no cpu_resp; empty=1, full=1 and the bus is 'z on the cycle after the edge where rst is sampled; a fresh read then completes correctly.
REQ-041 cpu_read and cpu_write asserted together in IDLE: a read is issued, with one TX word of tag 1.
